// File: rtl/capcnt_period_meas.sv
// Period measurement stage behind the capture counter: turns successive
// captured counts into a raw delta, a saturated signed error against the
// nominal delta, a windowed error sum, and a valid/ack result handshake.
module capcnt_period_meas #(
  parameter logic [31:0] NOMINAL  = 32'd2048000,
  parameter int          ERR_W    = 16,
  parameter logic [15:0] TOL      = 16'd200,
  parameter int          AVG_LOG2 = 3,
  parameter logic [31:0] TIMEOUT  = 32'd40000000
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      cap_stb,
  input  logic [31:0]               cnt_cap,
  output logic [31:0]               meas_delta,
  output logic [ERR_W-1:0]          meas_err,
  output logic                      meas_valid,
  input  logic                      meas_ack,
  output logic [ERR_W+AVG_LOG2-1:0] avg_sum,
  output logic                      avg_valid,
  output logic                      stat_range_err,
  output logic                      stat_overrun,
  output logic                      stat_lost,
  input  logic                      stat_clr
);

  localparam int AW = ERR_W + AVG_LOG2;
  // Saturation bounds of the ERR_W-bit signed error, held at 33 bits
  localparam logic signed [32:0] EMAX = (33'sd1 <<< (ERR_W-1)) - 33'sd1;
  localparam logic signed [32:0] EMIN = -(33'sd1 <<< (ERR_W-1));

  logic                    cap_dly_q;
  logic [31:0]             prev_q;
  logic                    have_prev_q;
  logic [31:0]             delta_q;
  logic                    dvld_q;
  logic [31:0]             to_q;
  logic                    lost_q;
  logic                    to_hit;
  logic signed [32:0]      e_full, e_ext, e_mag;
  logic [ERR_W-1:0]        e_sat;
  logic [AW-1:0]           e_acc;
  logic                    in_rng;
  logic [AW-1:0]           acc_q, acc_d, avg_q, avg_d;
  logic [AVG_LOG2-1:0]     wcnt_q, wcnt_d;
  logic                    avgv_q, avgv_d;
  logic [31:0]             mdelta_q;
  logic [ERR_W-1:0]        merr_q;
  logic                    mvld_q, mvld_d;
  logic                    rng_q, ovr_q;

  // A capture in the same cycle always beats the timeout
  assign to_hit = !cap_stb && (to_q == TIMEOUT - 32'd1);

  // Idle-cycle counter: restarted by every strobe, saturates at TIMEOUT
  always_ff @(posedge clk) begin
    if (rst) begin
      to_q   <= '0;
      lost_q <= 1'b0;
    end else if (cap_stb) begin
      to_q   <= '0;
      lost_q <= 1'b0;
    end else begin
      if (to_q != TIMEOUT) to_q <= to_q + 32'd1;
      if (to_hit)          lost_q <= 1'b1;
    end
  end

  // S0 strobe delay and S1 delta; first capture after reset/loss only primes
  always_ff @(posedge clk) begin
    if (rst) begin
      cap_dly_q   <= 1'b0;
      prev_q      <= '0;
      have_prev_q <= 1'b0;
      delta_q     <= '0;
      dvld_q      <= 1'b0;
    end else begin
      cap_dly_q <= cap_stb;
      dvld_q    <= cap_dly_q & have_prev_q;
      if (cap_dly_q) begin
        delta_q     <= cnt_cap - prev_q;
        prev_q      <= cnt_cap;
        have_prev_q <= 1'b1;
      end else if (to_hit) begin
        have_prev_q <= 1'b0;
      end
    end
  end

  // S2 error: 33-bit signed difference, saturated, then range-checked
  always_comb begin
    e_full = $signed({1'b0, delta_q}) - $signed({1'b0, NOMINAL});
    if (e_full > EMAX)      e_sat = EMAX[ERR_W-1:0];
    else if (e_full < EMIN) e_sat = EMIN[ERR_W-1:0];
    else                    e_sat = e_full[ERR_W-1:0];
    e_ext  = {{(33-ERR_W){e_sat[ERR_W-1]}}, e_sat};
    e_acc  = {{AVG_LOG2{e_sat[ERR_W-1]}}, e_sat};
    e_mag  = e_ext[32] ? -e_ext : e_ext;
    in_rng = (e_mag <= $signed({17'd0, TOL}));
  end

  // Averaging window next state; out-of-range or loss discards the partial window
  always_comb begin
    acc_d  = acc_q;
    wcnt_d = wcnt_q;
    avg_d  = avg_q;
    avgv_d = 1'b0;
    if (to_hit) begin
      acc_d  = '0;
      wcnt_d = '0;
    end else if (dvld_q) begin
      if (!in_rng) begin
        acc_d  = '0;
        wcnt_d = '0;
      end else if (&wcnt_q) begin
        avg_d  = acc_q + e_acc;
        avgv_d = 1'b1;
        acc_d  = '0;
        wcnt_d = '0;
      end else begin
        acc_d  = acc_q + e_acc;
        wcnt_d = wcnt_q + AVG_LOG2'(1);
      end
    end
  end

  // Handshake: new result sets valid (even with a coincident ack); ack clears
  always_comb begin
    mvld_d = mvld_q;
    if (dvld_q)                 mvld_d = 1'b1;
    else if (mvld_q && meas_ack) mvld_d = 1'b0;
  end

  // Result, window and sticky-flag registers; set events beat stat_clr
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q    <= '0;
      wcnt_q   <= '0;
      avg_q    <= '0;
      avgv_q   <= 1'b0;
      mdelta_q <= '0;
      merr_q   <= '0;
      mvld_q   <= 1'b0;
      rng_q    <= 1'b0;
      ovr_q    <= 1'b0;
    end else begin
      acc_q  <= acc_d;
      wcnt_q <= wcnt_d;
      avg_q  <= avg_d;
      avgv_q <= avgv_d;
      mvld_q <= mvld_d;
      if (dvld_q) begin
        mdelta_q <= delta_q;
        merr_q   <= e_sat;
      end
      rng_q <= (dvld_q & ~in_rng) | (rng_q & ~stat_clr);
      ovr_q <= (dvld_q & mvld_q & ~meas_ack) | (ovr_q & ~stat_clr);
    end
  end

  assign meas_delta     = mdelta_q;
  assign meas_err       = merr_q;
  assign meas_valid     = mvld_q;
  assign avg_sum        = avg_q;
  assign avg_valid      = avgv_q;
  assign stat_range_err = rng_q;
  assign stat_overrun   = ovr_q;
  assign stat_lost      = lost_q;

endmodule
